// File: rtl/norm_lshift_pkg.sv
// Shared FPU normalizer package: state encoding,
// default widths and the mantissa-width helper.
package norm_lshift_pkg;

   localparam int SWIDTH_DEF = 5;
   localparam int EWIDTH_DEF = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   // Mantissa width for a given log2 width.
   function automatic int w_of(input int s);
      return 1 << s;
   endfunction

endpackage

// File: rtl/norm_lshift_stage.sv
// One binary-search step of the leading-zero search.
// Ports: work_i/k_i in; work_o (shifted), hit_o (top 2**k bits zero) out.
module norm_lshift_stage
   import norm_lshift_pkg::*;
#(
   parameter int SWIDTH = SWIDTH_DEF,
   localparam int W = w_of(SWIDTH)
) (
   input  logic [W-1:0]      work_i,
   input  logic [SWIDTH-1:0] k_i,
   output logic [W-1:0]      work_o,
   output logic              hit_o
);

   logic [SWIDTH:0] sh;
   logic [W-1:0]    hi_mask;

   always_comb begin
      sh      = (SWIDTH+1)'(1) << k_i;
      // Mask selecting the top 2**k bits of the work word.
      hi_mask = ~({W{1'b1}} >> sh);
      hit_o   = (work_i & hi_mask) == '0;
      work_o  = hit_o ? (work_i << sh) : work_i;
   end

endmodule

// File: rtl/norm_lshift.sv
// Iterative left-shift normalizer: one LZC search step per clock.
// Ports: clk, rst; in_valid/in_ready, din, ein; out_valid/out_ready,
//        dout, cnt, eout, zero, uf (all outputs registered).
module norm_lshift
   import norm_lshift_pkg::*;
#(
   parameter int SWIDTH = SWIDTH_DEF,
   parameter int EWIDTH = EWIDTH_DEF,
   localparam int W = w_of(SWIDTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [W-1:0]      din,
   input  logic [EWIDTH-1:0] ein,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [W-1:0]      dout,
   output logic [SWIDTH-1:0] cnt,
   output logic [EWIDTH-1:0] eout,
   output logic              zero,
   output logic              uf
);

   // Wide enough to compare zero-extended cnt and exponent.
   localparam int XW = ((EWIDTH > SWIDTH) ? EWIDTH : SWIDTH) + 1;

   state_e            state_q;
   logic [W-1:0]      work_q;
   logic [EWIDTH-1:0] exp_q;
   logic [SWIDTH-1:0] k_q;
   logic [SWIDTH-1:0] cntw_q;

   logic              in_ready_q;
   logic              out_valid_q;
   logic [W-1:0]      dout_q;
   logic [SWIDTH-1:0] cnt_q;
   logic [EWIDTH-1:0] eout_q;
   logic              zero_q;
   logic              uf_q;

   logic [W-1:0]      work_d;
   logic              hit;
   logic [SWIDTH-1:0] cnt_d;
   logic [XW-1:0]     cnt_x;
   logic [XW-1:0]     exp_x;
   logic [XW-1:0]     diff_x;
   logic              zero_d;
   logic              uf_d;
   logic [EWIDTH-1:0] eout_d;

   norm_lshift_stage #(
      .SWIDTH (SWIDTH)
   ) u_stage (
      .work_i (work_q),
      .k_i    (k_q),
      .work_o (work_d),
      .hit_o  (hit)
   );

   always_comb begin
      cnt_d  = cntw_q | (hit ? (SWIDTH'(1) << k_q) : '0);
      cnt_x  = XW'(cnt_d);
      exp_x  = XW'(exp_q);
      diff_x = exp_x - cnt_x;
      // Only the final step's values are consumed (k==0),
      // where work_d is the fully normalized word.
      zero_d = (work_d == '0);
      uf_d   = !zero_d && (cnt_x > exp_x);
      eout_d = zero_d ? '0 : diff_x[EWIDTH-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         work_q      <= '0;
         exp_q       <= '0;
         k_q         <= '0;
         cntw_q      <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         dout_q      <= '0;
         cnt_q       <= '0;
         eout_q      <= '0;
         zero_q      <= 1'b0;
         uf_q        <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (in_valid) begin
                  work_q     <= din;
                  exp_q      <= ein;
                  cntw_q     <= '0;
                  k_q        <= SWIDTH'(SWIDTH-1);
                  in_ready_q <= 1'b0;
                  state_q    <= SHIFT;
               end
            end
            SHIFT: begin
               work_q <= work_d;
               cntw_q <= cnt_d;
               if (k_q == '0) begin
                  dout_q      <= work_d;
                  cnt_q       <= cnt_d;
                  eout_q      <= eout_d;
                  zero_q      <= zero_d;
                  uf_q        <= uf_d;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end else begin
                  k_q <= k_q - SWIDTH'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q     <= IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign dout      = dout_q;
   assign cnt       = cnt_q;
   assign eout      = eout_q;
   assign zero      = zero_q;
   assign uf        = uf_q;

endmodule

// File: tb/tb_norm_lshift.sv
// Self-checking bench for norm_lshift (SWIDTH=5, EWIDTH=8):
// directed cases plus random operands against a leading-zero model.
module tb_norm_lshift;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] din;
   logic [7:0]  ein;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] dout;
   logic [4:0]  cnt;
   logic [7:0]  eout;
   logic        zero;
   logic        uf;

   int nchk = 0;
   int nerr = 0;

   norm_lshift #(
      .SWIDTH (5),
      .EWIDTH (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .din       (din),
      .ein       (ein),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .dout      (dout),
      .cnt       (cnt),
      .eout      (eout),
      .zero      (zero),
      .uf        (uf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      nchk++;
      if (obs !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Reference: count leading zeros by scanning from the MSB.
   function automatic int ref_lzc(input logic [31:0] d);
      for (int i = 31; i >= 0; i--)
         if (d[i]) return 31 - i;
      return 31;
   endfunction

   task automatic check_out(input string tag,
                            input logic [31:0] d,
                            input logic [7:0] e);
      int          n;
      logic [31:0] xd;
      logic [7:0]  xe;
      logic        xz;
      logic        xu;
      n  = ref_lzc(d);
      xz = (d == 0);
      xd = xz ? 32'h0 : (d << n);
      xe = xz ? 8'h0 : 8'((int'(e) - n) & 255);
      xu = !xz && (n > int'(e));
      check({tag, ".dout"}, dout, xd);
      check({tag, ".cnt"}, 32'(cnt), 32'(n));
      check({tag, ".eout"}, 32'(eout), 32'(xe));
      check({tag, ".zero"}, 32'(zero), 32'(xz));
      check({tag, ".uf"}, 32'(uf), 32'(xu));
   endtask

   // Present an operand, accept it, wait for out_valid; leaves result pending.
   task automatic issue(input string tag,
                        input logic [31:0] d,
                        input logic [7:0] e);
      int lat;
      check({tag, ".rdy"}, 32'(in_ready), 32'd1);
      din      = d;
      ein      = e;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      din      = $urandom;
      ein      = 8'($urandom);
      lat      = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check({tag, ".lat"}, 32'(lat), 32'd5);
      check_out(tag, d, e);
   endtask

   task automatic drain(input string tag);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({tag, ".ovd"}, 32'(out_valid), 32'd0);
      check({tag, ".ird"}, 32'(in_ready), 32'd1);
   endtask

   logic [31:0] rd;
   logic [7:0]  re;

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      din       = '0;
      ein       = '0;
      #1;
      check("rst.ird", 32'(in_ready), 32'd1);
      check("rst.ovd", 32'(out_valid), 32'd0);
      check("rst.dout", dout, 32'd0);
      check("rst.cnt", 32'(cnt), 32'd0);
      check("rst.eout", 32'(eout), 32'd0);
      check("rst.zf", 32'({zero, uf}), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      issue("one", 32'h0000_0001, 8'd40);
      check("one.dv", dout, 32'h8000_0000);
      check("one.ev", 32'(eout), 32'd9);
      drain("one");

      issue("norm", 32'hDEAD_BEEF, 8'd100);
      drain("norm");

      issue("zero", 32'h0, 8'd77);
      check("zero.cv", 32'(cnt), 32'd31);
      drain("zero");

      issue("uf", 32'h0001_0000, 8'd10);
      check("uf.ev", 32'(eout), 32'd251);
      check("uf.uv", 32'(uf), 32'd1);
      // Hold the result; stray input pulse must be ignored.
      for (int i = 0; i < 6; i++) begin
         if (i == 2) begin
            din      = 32'h0000_0001;
            ein      = 8'd5;
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         @(posedge clk);
         #1;
         check("hold.ovd", 32'(out_valid), 32'd1);
         check("hold.ird", 32'(in_ready), 32'd0);
         check_out("hold", 32'h0001_0000, 8'd10);
      end
      in_valid = 1'b0;
      drain("hold");
      repeat (7) begin
         @(posedge clk);
         #1;
         check("stray.ovd", 32'(out_valid), 32'd0);
      end

      // Reset two edges into SHIFT discards the operation.
      din      = 32'h0000_0100;
      ein      = 8'd50;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("arst.dout", dout, 32'd0);
      check("arst.cnt", 32'(cnt), 32'd0);
      check("arst.eout", 32'(eout), 32'd0);
      check("arst.zf", 32'({zero, uf}), 32'd0);
      check("arst.ovd", 32'(out_valid), 32'd0);
      check("arst.ird", 32'(in_ready), 32'd1);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (7) begin
         @(posedge clk);
         #1;
         check("arst.novd", 32'(out_valid), 32'd0);
      end
      issue("post", 32'h00F0_0000, 8'd20);
      check("post.cv", 32'(cnt), 32'd8);
      check("post.dv", dout, 32'hF000_0000);
      drain("post");

      for (int t = 0; t < 150; t++) begin
         case ($urandom_range(0, 9))
            0:       rd = 32'h0;
            1:       rd = 32'h1 << $urandom_range(0, 31);
            default: rd = $urandom >> $urandom_range(0, 31);
         endcase
         re = 8'($urandom);
         issue("rnd", rd, re);
         if ($urandom_range(0, 3) == 0)
            repeat ($urandom_range(1, 4)) @(posedge clk);
         drain("rnd");
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
